// File: rtl/uart_mul_pkg.sv
// Shared definitions for the UART multiplier sequencer.
// Optional build macro: UART_MUL_SIGNED_EN (two's complement operands/product).
package uart_mul_pkg;

  localparam int OPERAND_W  = 8;
  localparam int PRODUCT_W  = 16;
  localparam int MUL_CYCLES = 8;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    MUL     = 3'd2,
    SEND_HI = 3'd3,
    WAIT_HI = 3'd4,
    SEND_LO = 3'd5,
    WAIT_LO = 3'd6
  } mul_state_t;

  // Magnitude of an operand; only negative values in signed mode are negated.
  // -128 maps to 0x80, which is still the correct unsigned magnitude.
  function automatic logic [OPERAND_W-1:0] operand_mag(input logic [OPERAND_W-1:0] v,
                                                       input logic is_signed);
    logic [OPERAND_W-1:0] r;
    if (is_signed && v[OPERAND_W-1]) begin
      r = ~v + 8'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult.sv
// Sequential 8x8 shift-add multiplier with start/done handshake.
// start_i loads the operands; MUL_CYCLES later done_o pulses for one cycle
// together with the new product_o value.
// Optional build macro: UART_MUL_SIGNED_EN (multiply magnitudes, then negate
// when the operand signs differ; latency unchanged).
module seq_shift_add_mult
  import uart_mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [OPERAND_W-1:0] a_i,
  input  logic [OPERAND_W-1:0] b_i,
  output logic                 done_o,
  output logic [PRODUCT_W-1:0] product_o
);

`ifdef UART_MUL_SIGNED_EN
  localparam logic SIGNED_OP = 1'b1;
`else
  localparam logic SIGNED_OP = 1'b0;
`endif

  localparam logic [2:0] CNT_LAST = 3'(MUL_CYCLES - 1);

  logic [PRODUCT_W-1:0] mcand_q, mcand_d;
  logic [OPERAND_W-1:0] mplier_q, mplier_d;
  logic [PRODUCT_W-1:0] acc_q, acc_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 run_q, run_d;
  logic                 neg_q, neg_d;
  logic                 done_q, done_d;
  logic [PRODUCT_W-1:0] product_q, product_d;
  logic [PRODUCT_W-1:0] acc_next_s;

  // Next-state logic: load on start, one add-and-shift step per running cycle.
  always_comb begin
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    run_d      = run_q;
    neg_d      = neg_q;
    done_d     = 1'b0;
    product_d  = product_q;
    acc_next_s = acc_q + (mplier_q[0] ? mcand_q : 16'd0);
    if (start_i) begin
      mcand_d  = {8'd0, operand_mag(a_i, SIGNED_OP)};
      mplier_d = operand_mag(b_i, SIGNED_OP);
      acc_d    = 16'd0;
      cnt_d    = CNT_LAST;
      run_d    = 1'b1;
      neg_d    = SIGNED_OP & (a_i[OPERAND_W-1] ^ b_i[OPERAND_W-1]);
    end else if (run_q) begin
      acc_d    = acc_next_s;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == 3'd0) begin
        run_d     = 1'b0;
        done_d    = 1'b1;
        product_d = neg_q ? (~acc_next_s + 16'd1) : acc_next_s;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= 16'd0;
      mplier_q  <= 8'd0;
      acc_q     <= 16'd0;
      cnt_q     <= 3'd0;
      run_q     <= 1'b0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
      product_q <= 16'd0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: rtl/uart_mul_sequencer.sv
// Byte command sequencer: receives operands A and B, multiplies them and
// returns the 16-bit product high byte first over the tx start/ready handshake.
// Optional build macro: UART_MUL_SIGNED_EN (passed through to the multiplier).
module uart_mul_sequencer
  import uart_mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPERAND_W-1:0] rx_data,
  input  logic                 rx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic                 busy,
  output logic                 overrun,
  output logic [PRODUCT_W-1:0] product
);

  mul_state_t           state_q, state_d;
  logic [OPERAND_W-1:0] a_q, a_d;
  logic                 seen_low_q, seen_low_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic [PRODUCT_W-1:0] product_q, product_d;

  logic                 mul_start_s;
  logic                 mul_done_s;
  logic [PRODUCT_W-1:0] mul_product_s;

  seq_shift_add_mult u_mult (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start_s),
    .a_i       (a_q),
    .b_i       (rx_data),
    .done_o    (mul_done_s),
    .product_o (mul_product_s)
  );

  // Next-state and output logic. When the multiply finishes with the
  // transmitter idle, the high byte is launched directly so that tx_start
  // appears in the same cycle as the new product.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    seen_low_d  = seen_low_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    overrun_d   = overrun_q;
    product_d   = product_q;
    mul_start_s = 1'b0;

    if (rx_valid && (state_q != GET_A) && (state_q != GET_B)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      GET_A: begin
        if (rx_valid) begin
          a_d     = rx_data;
          state_d = GET_B;
        end else begin
          state_d = GET_A;
        end
      end
      GET_B: begin
        if (rx_valid) begin
          mul_start_s = 1'b1;
          state_d     = MUL;
        end else begin
          state_d = GET_B;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          product_d = mul_product_s;
          if (tx_ready) begin
            tx_data_d  = mul_product_s[15:8];
            tx_start_d = 1'b1;
            seen_low_d = 1'b0;
            state_d    = WAIT_HI;
          end else begin
            state_d = SEND_HI;
          end
        end else begin
          state_d = MUL;
        end
      end
      SEND_HI: begin
        if (tx_ready) begin
          tx_data_d  = product_q[15:8];
          tx_start_d = 1'b1;
          seen_low_d = 1'b0;
          state_d    = WAIT_HI;
        end else begin
          state_d = SEND_HI;
        end
      end
      WAIT_HI: begin
        if (!seen_low_q) begin
          seen_low_d = !tx_ready;
        end else if (tx_ready) begin
          state_d = SEND_LO;
        end else begin
          state_d = WAIT_HI;
        end
      end
      SEND_LO: begin
        if (tx_ready) begin
          tx_data_d  = product_q[7:0];
          tx_start_d = 1'b1;
          seen_low_d = 1'b0;
          state_d    = WAIT_LO;
        end else begin
          state_d = SEND_LO;
        end
      end
      WAIT_LO: begin
        if (!seen_low_q) begin
          seen_low_d = !tx_ready;
        end else if (tx_ready) begin
          state_d = GET_A;
        end else begin
          state_d = WAIT_LO;
        end
      end
      default: begin
        state_d = GET_A;
      end
    endcase

    busy_d = (state_d != GET_A);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= GET_A;
      a_q        <= 8'd0;
      seen_low_q <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      product_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      seen_low_q <= seen_low_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      product_q  <= product_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign product  = product_q;

endmodule

// File: tb/tb_uart_mul_sequencer.sv
// Scoreboard bench for uart_mul_sequencer: expected tx bytes are queued when
// operands are driven and compared whenever the DUT pulses tx_start.
module tb_uart_mul_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        overrun;
  logic [15:0] product;

  int          n_vec;
  int          n_err;
  logic [7:0]  exp_q[$];
  int          bytes_pushed;
  int          starts_seen;
  logic        prev_start;
  logic        rdy_at_edge;
  logic [7:0]  last_tx;
  logic        hold_low;
  int          tx_busy_cycles;

  uart_mul_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy),
    .overrun  (overrun),
    .product  (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b);
`ifdef UART_MUL_SIGNED_EN
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
`else
    return {8'd0, a} * {8'd0, b};
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Returns at the negedge following the edge that samples B.
  task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input bit push);
    logic [15:0] p;
    if (push) begin
      p = model_mul(a, b);
      exp_q.push_back(p[15:8]);
      exp_q.push_back(p[7:0]);
      bytes_pushed = bytes_pushed + 2;
    end
    send_byte(a);
    @(negedge clk);
    send_byte(b);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
    check_val("idle_timeout", busy, 0);
  endtask

  // DUT's view of tx_ready at each active edge.
  always @(posedge clk) rdy_at_edge <= tx_ready;

  // Scoreboard monitor: every tx_start pops and compares one expected byte.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      starts_seen <= starts_seen + 1;
      check_val("start_len", prev_start, 0);
      check_val("start_ready", rdy_at_edge, 1);
      check_val("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check_val("tx_byte", tx_data, exp_q[0]);
        last_tx <= exp_q[0];
        void'(exp_q.pop_front());
      end
    end
    prev_start <= tx_start;
  end

  // Transmitter model: drops ready after each start for tx_busy_cycles.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (hold_low) begin
        tx_ready = 1'b0;
      end else if (tx_start === 1'b1) begin
        tx_ready = 1'b0;
        repeat (tx_busy_cycles) @(negedge clk);
        tx_ready = 1'b1;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  initial begin
    int cnt;
    logic [15:0] p;
    n_vec = 0; n_err = 0; bytes_pushed = 0; starts_seen = 0;
    prev_start = 1'b0; last_tx = 8'd0; hold_low = 1'b0; tx_busy_cycles = 3;
    reset = 1'b1; rx_data = 8'd0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_tx_data", tx_data, 0);
    check_val("rst_tx_start", tx_start, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_overrun", overrun, 0);
    check_val("rst_product", product, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic: 0x0C x 0x0B, latency to product and first tx_start.
    do_txn(8'h0C, 8'h0B, 1'b1);
    check_val("busy_in_mul", busy, 1);
    repeat (8) @(negedge clk);
    check_val("prod_early", product, 0);
    check_val("start_early", tx_start, 0);
    @(negedge clk);
    check_val("prod_n9", product, 16'h0084);
    check_val("start_n9", tx_start, 1);
    wait_idle(200);

    // Maximum operands.
    do_txn(8'hFF, 8'hFF, 1'b1);
    wait_idle(200);
    check_val("prod_max", product, model_mul(8'hFF, 8'hFF));
`ifdef UART_MUL_SIGNED_EN
    do_txn(8'hFF, 8'h02, 1'b1);
    wait_idle(200);
    do_txn(8'h80, 8'h80, 1'b1);
    wait_idle(200);
    check_val("prod_m128sq", product, 16'h4000);
`endif

    // Backpressure: transmitter held busy for 50 cycles after the multiply.
    hold_low = 1'b1;
    @(negedge clk);
    do_txn(8'h12, 8'h34, 1'b1);
    repeat (10) @(negedge clk);
    check_val("bp_product", product, model_mul(8'h12, 8'h34));
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) cnt = cnt + 1;
    end
    check_val("bp_no_start", cnt, 0);
    check_val("bp_tx_stable", tx_data, last_tx);
    hold_low = 1'b0;
    wait_idle(200);
    check_val("bp_starts", starts_seen, bytes_pushed);

    // Overrun: stray byte during MUL.
    do_txn(8'h07, 8'h09, 1'b1);
    @(negedge clk);
    send_byte(8'h55);
    check_val("ovr_set", overrun, 1);
    wait_idle(200);
    check_val("ovr_product", product, 16'h003F);
    do_txn(8'h02, 8'h03, 1'b1);
    wait_idle(200);
    check_val("ovr_next_prod", product, 16'h0006);
    check_val("ovr_sticky", overrun, 1);

    // Reset in the middle of a multiply.
    do_txn(8'h10, 8'h10, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mrst_tx_data", tx_data, 0);
    check_val("mrst_tx_start", tx_start, 0);
    check_val("mrst_busy", busy, 0);
    check_val("mrst_overrun", overrun, 0);
    check_val("mrst_product", product, 0);
    @(negedge clk);
    check_val("mrst_start_after", tx_start, 0);
    check_val("mrst_busy_after", busy, 0);
    do_txn(8'h03, 8'h05, 1'b1);
    wait_idle(200);
    check_val("mrst_new_prod", product, 16'h000F);

    // Back-to-back with a slow transmitter.
    tx_busy_cycles = 100;
    do_txn(8'h12, 8'h34, 1'b1);
    wait_idle(1000);
    do_txn(8'hA5, 8'h5A, 1'b1);
    wait_idle(1000);
    do_txn(8'h00, 8'hFF, 1'b1);
    wait_idle(1000);
    p = model_mul(8'h00, 8'hFF);
    check_val("b2b_product", product, p);
    check_val("b2b_overrun", overrun, 0);

    repeat (2) @(negedge clk);
    check_val("sb_drained", exp_q.size(), 0);
    check_val("start_total", starts_seen, bytes_pushed);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
